// File: rtl/laser_pkg.sv
// Shared definitions for the laser bank mapper.
// Contents:
//   state_t    - mapper FSM states (IDLE, DIO, CPU, DONE)
//   DEF_*      - default slot count, page width, port and page-map constants
package laser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIO  = 2'd1,
    ST_CPU  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         DEF_NUM_SLOTS = 4;
  localparam int         DEF_PAGE_W    = 4;
  localparam int         DEF_ADDR_W    = 25;
  localparam int         DEF_RAM_FIRST = 4;
  localparam int         DEF_RAM_LAST  = 7;
  localparam int         DEF_IO_PAGE   = 2;
  localparam logic [7:0] DEF_BANK_PORT = 8'h40;

endpackage

// File: rtl/laser_bank_regs.sv
// Bank register file with I/O port decode.
// One PAGE_W-bit page register per CPU address slot. An OUT to one of the
// NUM_SLOTS consecutive ports starting at BANK_PORT loads the register
// selected by the low port bits, once per I/O write strobe.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (clears all banks)
//   port       - low byte of the CPU address (I/O port number)
//   data       - CPU write data
//   iorq_n     - Z80 IORQ, active low
//   wr_n       - Z80 WR, active low
//   bank_q     - all bank registers, slot 0 in the LSBs
module laser_bank_regs
  import laser_pkg::*;
#(
  parameter int         NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int         PAGE_W    = DEF_PAGE_W,
  parameter logic [7:0] BANK_PORT = DEF_BANK_PORT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  port,
  input  logic [7:0]                  data,
  input  logic                        iorq_n,
  input  logic                        wr_n,
  output logic [NUM_SLOTS*PAGE_W-1:0] bank_q
);

  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam logic [8:0] PORT_LO = {1'b0, BANK_PORT};
  localparam logic [8:0] PORT_HI = PORT_LO + 9'(NUM_SLOTS);

  logic [PAGE_W-1:0] bank [NUM_SLOTS];
  logic              io_wr;
  logic              io_wr_prev;
  logic              port_hit;

  assign io_wr    = !iorq_n && !wr_n;
  // 9-bit compare so a port range ending at 0xFF does not wrap
  assign port_hit = ({1'b0, port} >= PORT_LO) && ({1'b0, port} < PORT_HI);

  // The Z80 holds IORQ/WR low for several clocks; only the leading edge writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_wr_prev <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) bank[i] <= '0;
    end else begin
      io_wr_prev <= io_wr;
      if (io_wr && !io_wr_prev && port_hit)
        bank[port[SLOT_BITS-1:0]] <= data[PAGE_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign bank_q[g*PAGE_W +: PAGE_W] = bank[g];
  end

endmodule

// File: rtl/laser_bank_mapper.sv
// Z80 bank mapper in front of an SDRAM request/acknowledge port.
// Translates CPU memory cycles through per-slot bank registers, decodes a
// mapped-I/O page, discards writes to ROM pages, and interleaves ROM
// download writes (priority) with CPU accesses through one memory port.
// Ports:
//   F14M, RESET            - clock, asynchronous active-high reset
//   cpu_*                  - Z80 bus (active-low strobes), read data, WAIT
//   dio_*                  - ROM download write port (one-cycle dio_write)
//   mem_req/we/addr/din    - SDRAM request, held stable until mem_ack
//   mem_ack, mem_dout      - SDRAM completion pulse and read data
//   mapped_io              - current CPU memory cycle hits the I/O page
//   bank_q                 - bank registers, slot 0 in the LSBs
//   dio_overrun            - sticky: a download write was dropped
module laser_bank_mapper
  import laser_pkg::*;
#(
  parameter int         NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int         PAGE_W    = DEF_PAGE_W,
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         RAM_FIRST = DEF_RAM_FIRST,
  parameter int         RAM_LAST  = DEF_RAM_LAST,
  parameter int         IO_PAGE   = DEF_IO_PAGE,
  parameter logic [7:0] BANK_PORT = DEF_BANK_PORT
) (
  input  logic                        F14M,
  input  logic                        RESET,
  input  logic [15:0]                 cpu_addr,
  input  logic [7:0]                  cpu_dout,
  input  logic                        cpu_mreq_n,
  input  logic                        cpu_iorq_n,
  input  logic                        cpu_rd_n,
  input  logic                        cpu_wr_n,
  output logic [7:0]                  cpu_din,
  output logic                        cpu_wait_n,
  input  logic                        dio_download,
  input  logic                        dio_write,
  input  logic [ADDR_W-1:0]           dio_addr,
  input  logic [7:0]                  dio_data,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [7:0]                  mem_din,
  input  logic                        mem_ack,
  input  logic [7:0]                  mem_dout,
  output logic                        mapped_io,
  output logic [NUM_SLOTS*PAGE_W-1:0] bank_q,
  output logic                        dio_overrun
);

  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int OFS_W     = 16 - SLOT_BITS;
  localparam logic [PAGE_W-1:0] IO_PG  = PAGE_W'(IO_PAGE);
  localparam logic [PAGE_W-1:0] RAM_LO = PAGE_W'(RAM_FIRST);
  localparam logic [PAGE_W-1:0] RAM_HI = PAGE_W'(RAM_LAST);

  state_t                      state_q, state_d;
  logic [NUM_SLOTS*PAGE_W-1:0] bank_flat;
  logic [SLOT_BITS-1:0]        slot;
  logic [PAGE_W-1:0]           page;
  logic                        cpu_cyc, is_io, is_ram, rom_wr, cpu_go;
  logic                        dio_new, pend_release;
  logic                        pend_vld;
  logic [ADDR_W-1:0]           pend_addr;
  logic [7:0]                  pend_data;
  logic                        wait_busy;

  laser_bank_regs #(
    .NUM_SLOTS (NUM_SLOTS),
    .PAGE_W    (PAGE_W),
    .BANK_PORT (BANK_PORT)
  ) u_bank_regs (
    .clk    (F14M),
    .rst    (RESET),
    .port   (cpu_addr[7:0]),
    .data   (cpu_dout),
    .iorq_n (cpu_iorq_n),
    .wr_n   (cpu_wr_n),
    .bank_q (bank_flat)
  );

  assign bank_q = bank_flat;
  assign slot   = cpu_addr[15 -: SLOT_BITS];

  always_comb begin
    page = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (slot == SLOT_BITS'(i)) page = bank_flat[i*PAGE_W +: PAGE_W];
  end

  // Classify the CPU cycle: mapped I/O and ROM writes never reach memory
  assign cpu_cyc = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
  assign is_io   = (page == IO_PG);
  assign is_ram  = (page >= RAM_LO) && (page <= RAM_HI);
  assign rom_wr  = !cpu_wr_n && !is_ram;
  assign cpu_go  = cpu_cyc && !is_io && !rom_wr;

  // A download write arriving this cycle already outranks a CPU request
  assign dio_new      = dio_write && dio_download;
  assign pend_release = (state_q == ST_DIO) && mem_ack;

  // FSM state register
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_vld || dio_new) state_d = ST_DIO;
        else if (cpu_go)         state_d = ST_CPU;
        else if (cpu_cyc)        state_d = ST_DONE;
      end
      ST_DIO:  if (mem_ack)    state_d = ST_IDLE;
      ST_CPU:  if (mem_ack)    state_d = ST_DONE;
      ST_DONE: if (cpu_mreq_n) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; WAIT is forced high while RESET is asserted
  always_comb begin
    mapped_io = cpu_cyc && is_io;
    wait_busy = 1'b0;
    case (state_q)
      ST_IDLE, ST_DIO: wait_busy = cpu_go;
      ST_CPU:          wait_busy = !mem_ack;
      default:         wait_busy = 1'b0;
    endcase
    cpu_wait_n = RESET || !wait_busy;
  end

  // Memory request side and CPU read data
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      cpu_din <= 8'hFF;
    end else begin
      mem_req <= ((state_q == ST_CPU) || (state_q == ST_DIO)) && !mem_ack;
      if (state_q == ST_IDLE && state_d == ST_DIO) begin
        mem_we   <= 1'b1;
        mem_addr <= pend_vld ? pend_addr : dio_addr;
        mem_din  <= pend_vld ? pend_data : dio_data;
      end else if (state_q == ST_IDLE && state_d == ST_CPU) begin
        mem_we   <= !cpu_wr_n;
        mem_addr <= ADDR_W'({page, cpu_addr[OFS_W-1:0]});
        mem_din  <= cpu_dout;
      end
      if (state_q == ST_CPU && mem_ack && !mem_we)
        cpu_din <= mem_dout;
    end
  end

  // One-deep download buffer stays occupied until its write is acknowledged
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      pend_vld    <= 1'b0;
      dio_overrun <= 1'b0;
    end else if (dio_new) begin
      if (pend_vld && !pend_release) dio_overrun <= 1'b1;
      else                           pend_vld    <= 1'b1;
    end else if (pend_release) begin
      pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge F14M) begin
    if (dio_new && (!pend_vld || pend_release)) begin
      pend_addr <= dio_addr;
      pend_data <= dio_data;
    end
  end

endmodule
